// File: rtl/self_output_writeback.sv
// AXI4 write master draining the int8 LayerNorm result stream into DDR as
// fixed-length INCR bursts, with a small input FIFO and done/error status.
//
// Ports:
//   clk, rstn_pl            clock, async active-low reset
//   start, base_addr        1-cycle start pulse, DDR byte address of row 0
//   s_tdata/tvalid/tready   result stream in (byte 0 = lowest address)
//   m_axi_aw*               write address channel (awlen = BURST_LEN-1)
//   m_axi_w*                write data channel (data = FIFO head)
//   m_axi_b*                write response channel
//   done, error             level status, cleared by the next start
//
// Build option: define SO_WB_ALIGN_CHECK_EN to reject a base_addr that is
// not aligned to one burst (error on start, no AW issued).

module self_output_writeback #(
    parameter int TOKENS     = 32,
    parameter int EMBED      = 768,
    parameter int DATA_W     = 128,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rstn_pl,
    input  logic              start,
    input  logic [63:0]       base_addr,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [63:0]       m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic              done,
    output logic              error
);

    localparam int TOTAL_BEATS = TOKENS * EMBED * 8 / DATA_W;
    localparam int NBURST      = TOTAL_BEATS / BURST_LEN;
    localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
    localparam int ACC_W  = $clog2(TOTAL_BEATS + 1);
    localparam int BI_W   = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [ACC_W-1:0]  TOTAL_C    = ACC_W'(TOTAL_BEATS);
    localparam logic [BI_W-1:0]   LAST_BURST = BI_W'(NBURST - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BURST_C    = CNT_W'(BURST_LEN);
    localparam logic [PTR_W-1:0]  PTR_MAX    = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [BEAT_W-1:0] BEAT_PEN   = BEAT_W'(BURST_LEN - 2);
    localparam logic [63:0]       BURST_STEP = 64'(BURST_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ACC_W-1:0]  accepted;
    logic [BI_W-1:0]   burst_idx;
    logic [BEAT_W-1:0] beat_cnt;

    logic active;
    logic push;
    logic pop;
    logic restart;
    logic misaligned;

    assign active = (state == S_AW) || (state == S_W) || (state == S_B);

    assign s_tready = active && (count != DEPTH_C) && (accepted != TOTAL_C);
    assign push     = s_tvalid && s_tready;
    assign pop      = m_axi_wvalid && m_axi_wready;

    // A new start is honoured only when no transfer is in flight.
    assign restart = start &&
        ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

`ifdef SO_WB_ALIGN_CHECK_EN
    // A burst-aligned base keeps every burst inside one 4 KB page.
    assign misaligned = |base_addr[$clog2(BURST_BYTES)-1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign m_axi_awlen = 8'(BURST_LEN - 1);
    assign m_axi_wdata = m_axi_wvalid ? mem[rd_ptr] : '0;

    // Storage is not reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk or negedge rstn_pl) begin
        if (!rstn_pl) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            accepted      <= '0;
            burst_idx     <= '0;
            beat_cnt      <= '0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wlast   <= 1'b0;
            m_axi_bready  <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else if (restart) begin
            // Flush anything left behind by an aborted (ERR) transfer.
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            accepted      <= '0;
            burst_idx     <= '0;
            beat_cnt      <= '0;
            m_axi_awaddr  <= base_addr;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wlast   <= 1'b0;
            m_axi_bready  <= 1'b0;
            done          <= 1'b0;
            if (misaligned) begin
                error <= 1'b1;
                state <= S_ERR;
            end else begin
                error <= 1'b0;
                state <= S_AW;
            end
        end else begin
            if (push) begin
                wr_ptr   <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
                accepted <= accepted + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            unique case (state)
                S_AW: begin
                    // Hold AW back until a whole burst is buffered so the
                    // W phase can never starve mid-burst.
                    if (!m_axi_awvalid) begin
                        if (count >= BURST_C) begin
                            m_axi_awvalid <= 1'b1;
                        end
                    end else if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_wlast   <= (BURST_LEN == 1);
                        beat_cnt      <= '0;
                        state         <= S_W;
                    end
                end
                S_W: begin
                    if (pop) begin
                        if (m_axi_wlast) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_wlast  <= 1'b0;
                            m_axi_bready <= 1'b1;
                            state        <= S_B;
                        end else begin
                            beat_cnt    <= beat_cnt + 1'b1;
                            m_axi_wlast <= (beat_cnt == BEAT_PEN);
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) begin
                            error <= 1'b1;
                            state <= S_ERR;
                        end else if (burst_idx == LAST_BURST) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            burst_idx    <= burst_idx + 1'b1;
                            m_axi_awaddr <= m_axi_awaddr + BURST_STEP;
                            state        <= S_AW;
                        end
                    end
                end
                S_IDLE, S_DONE, S_ERR: begin
                    state <= state;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_self_output_writeback.sv
// Scoreboard bench for self_output_writeback: expected AW addresses and W
// beats are queued at stimulus time and checked by an independent monitor.

module tb_self_output_writeback;

    localparam int TOTAL = 1536;
    localparam int NB    = 96;
    localparam int BL    = 16;

    logic         sim_clk = 1'b0;
    logic         rstn_pl = 1'b0;
    logic         start = 1'b0;
    logic [63:0]  base_addr = '0;
    logic [127:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [63:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic         m_axi_awvalid;
    logic         m_axi_awready = 1'b1;
    logic [127:0] m_axi_wdata;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready = 1'b1;
    logic [1:0]   m_axi_bresp = 2'b00;
    logic         m_axi_bvalid = 1'b0;
    logic         m_axi_bready;
    logic         done;
    logic         error;

    always #5 sim_clk = ~sim_clk;

    self_output_writeback dut (
        .clk           (sim_clk),
        .rstn_pl       (rstn_pl),
        .start         (start),
        .base_addr     (base_addr),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .done          (done),
        .error         (error)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0]  aw_q [$];
    logic [127:0] w_q  [$];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Stream byte n carries n[7:0].
    function automatic logic [127:0] beat_data(input int k);
        logic [127:0] d;
        for (int j = 0; j < 16; j++) begin
            d[8*j +: 8] = 8'(16 * k + j);
        end
        return d;
    endfunction

    // ---------------- monitor ----------------
    int           mon_out = 0;
    int           mon_w = 0;
    logic         aw_st = 1'b0;
    logic         w_st = 1'b0;
    logic [63:0]  aw_pa = '0;
    logic [127:0] w_pd = '0;

    initial begin
        forever begin
            @(negedge sim_clk);
            if (!rstn_pl) begin
                mon_out = 0;
                mon_w   = 0;
                aw_st   = 1'b0;
                w_st    = 1'b0;
            end else begin
                if (aw_st) begin
                    chk("aw_hold_valid", 128'(m_axi_awvalid), 128'(1));
                    chk("aw_hold_addr", 128'(m_axi_awaddr), 128'(aw_pa));
                end
                if (w_st) begin
                    chk("w_hold_valid", 128'(m_axi_wvalid), 128'(1));
                    chk("w_hold_data", m_axi_wdata, w_pd);
                end
                if (m_axi_awvalid && m_axi_awready) begin
                    chk("aw_outstanding", 128'(mon_out), 128'(0));
                    chk("awlen", 128'(m_axi_awlen), 128'(BL - 1));
                    if (aw_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL aw_extra got addr %0h want none",
                                 m_axi_awaddr);
                    end else begin
                        chk("awaddr", 128'(m_axi_awaddr),
                            128'(aw_q.pop_front()));
                    end
                    mon_out++;
                    mon_w = 0;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    chk("w_after_aw", 128'(mon_out), 128'(1));
                    chk("wlast", 128'(m_axi_wlast), 128'(mon_w == BL - 1));
                    if (w_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL w_extra got %0h want none",
                                 m_axi_wdata);
                    end else begin
                        chk("wdata", m_axi_wdata, w_q.pop_front());
                    end
                    mon_w++;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    mon_out--;
                end
                aw_st = m_axi_awvalid && !m_axi_awready;
                aw_pa = m_axi_awaddr;
                w_st  = m_axi_wvalid && !m_axi_wready;
                w_pd  = m_axi_wdata;
            end
        end
    end

    // ---------------- source + slave model ----------------
    int src_idx = 0;
    bit src_on = 1'b0;
    bit bp = 1'b0;
    int b_idx = 0;
    bit b_pend = 1'b0;
    int b_wait = 0;
    int err_burst = -1;
    bit stall_arm = 1'b0;
    int stall_cnt = 0;
    int aw_seen = 0;

    task automatic tick();
        logic s_f, aw_f, wl_f, b_f;
        @(negedge sim_clk);
        s_f  = s_tvalid && s_tready;
        aw_f = m_axi_awvalid && m_axi_awready;
        wl_f = m_axi_wvalid && m_axi_wready && m_axi_wlast;
        b_f  = m_axi_bvalid && m_axi_bready;
        @(posedge sim_clk);
        #1;
        if (s_f) src_idx++;
        if (!(s_tvalid && !s_f)) begin
            s_tvalid = src_on && (src_idx < TOTAL) &&
                       (!bp || $urandom_range(0, 3) != 0);
        end
        s_tdata = beat_data(src_idx);
        if (aw_f) begin
            aw_seen++;
            if (stall_arm) begin
                stall_cnt = 100;
                stall_arm = 1'b0;
            end
        end
        if (wl_f) begin
            b_pend = 1'b1;
            b_wait = bp ? int'($urandom_range(0, 7)) : 0;
        end
        if (b_f) begin
            m_axi_bvalid = 1'b0;
            m_axi_bresp  = 2'b00;
            b_idx++;
        end
        if (b_pend && !m_axi_bvalid) begin
            if (b_wait == 0) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
                b_pend = 1'b0;
            end else begin
                b_wait--;
            end
        end
        m_axi_awready = !bp || ($urandom_range(0, 2) == 0);
        if (stall_cnt > 0) begin
            m_axi_wready = 1'b0;
            stall_cnt--;
        end else begin
            m_axi_wready = !bp || ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic run_start(input logic [63:0] base, input int nexp,
                             input int errb, input bit bp_in,
                             input bit stall_in);
        aw_q.delete();
        w_q.delete();
        for (int i = 0; i < nexp; i++) begin
            aw_q.push_back(base + 64'(i * 256));
            for (int j = 0; j < BL; j++) begin
                w_q.push_back(beat_data(i * BL + j));
            end
        end
        src_idx   = 0;
        src_on    = 1'b1;
        b_idx     = 0;
        b_pend    = 1'b0;
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        err_burst = errb;
        bp        = bp_in;
        stall_arm = stall_in;
        stall_cnt = 0;
        aw_seen   = 0;
        base_addr = base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_end(input string nm, input int maxc);
        int n = 0;
        while (!(done || error) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got %0d cycles want < %0d", nm, n, maxc);
        end
    endtask

    task automatic end_checks(input string nm, input bit exp_done,
                              input bit exp_err);
        chk({nm, "_done"}, 128'(done), 128'(exp_done));
        chk({nm, "_error"}, 128'(error), 128'(exp_err));
        chk({nm, "_aw_left"}, 128'(aw_q.size()), 128'(0));
        chk({nm, "_w_left"}, 128'(w_q.size()), 128'(0));
    endtask

    task automatic zero_checks(input string nm);
        chk({nm, "_s_tready"}, 128'(s_tready), 128'(0));
        chk({nm, "_awvalid"}, 128'(m_axi_awvalid), 128'(0));
        chk({nm, "_awaddr"}, 128'(m_axi_awaddr), 128'(0));
        chk({nm, "_wvalid"}, 128'(m_axi_wvalid), 128'(0));
        chk({nm, "_wlast"}, 128'(m_axi_wlast), 128'(0));
        chk({nm, "_wdata"}, m_axi_wdata, 128'(0));
        chk({nm, "_bready"}, 128'(m_axi_bready), 128'(0));
        chk({nm, "_done"}, 128'(done), 128'(0));
        chk({nm, "_error"}, 128'(error), 128'(0));
    endtask

    initial begin
        int n;
        rstn_pl = 1'b0;
        repeat (3) @(posedge sim_clk);
        #1;
        zero_checks("reset");
        rstn_pl = 1'b1;
        tick();

        // nominal
        run_start(64'h4_0000, NB, -1, 1'b0, 1'b0);
        wait_end("nominal", 20000);
        end_checks("nominal", 1'b1, 1'b0);

        // backpressure and stream bubbles
        run_start(64'h4_0000, NB, -1, 1'b1, 1'b0);
        wait_end("backpressure", 40000);
        end_checks("backpressure", 1'b1, 1'b0);

        // SLVERR on burst 5: exactly 6 AWs, then nothing more
        run_start(64'h4_0000, 6, 5, 1'b0, 1'b0);
        wait_end("bresp_err", 5000);
        repeat (20) tick();
        end_checks("bresp_err", 1'b0, 1'b1);

        // restart after error
        run_start(64'h4_0000, NB, -1, 1'b0, 1'b0);
        wait_end("restart", 20000);
        end_checks("restart", 1'b1, 1'b0);

        // FIFO fills while wready is held low after the first AW
        run_start(64'h4_0000, NB, -1, 1'b0, 1'b1);
        n = 0;
        while (aw_seen == 0 && n < 200) begin
            tick();
            n++;
        end
        chk("fifo_first_aw", 128'(aw_seen), 128'(1));
        repeat (90) tick();
        chk("fifo_full_tready", 128'(s_tready), 128'(0));
        chk("fifo_full_beats", 128'(src_idx), 128'(32));
        wait_end("fifo_full", 20000);
        end_checks("fifo_full", 1'b1, 1'b0);

        // reset during the W phase of burst 10
        run_start(64'h4_0000, NB, -1, 1'b0, 1'b0);
        n = 0;
        while (!(b_idx == 10 && m_axi_wvalid) && n < 5000) begin
            tick();
            n++;
        end
        chk("rst_reached_b10", 128'(b_idx), 128'(10));
        rstn_pl = 1'b0;
        #1;
        zero_checks("midrst");
        aw_q.delete();
        w_q.delete();
        src_on = 1'b0;
        b_pend = 1'b0;
        m_axi_bvalid = 1'b0;
        repeat (3) tick();
        rstn_pl = 1'b1;
        tick();
        run_start(64'h4_0000, NB, -1, 1'b0, 1'b0);
        wait_end("post_reset", 20000);
        end_checks("post_reset", 1'b1, 1'b0);

        // unaligned base
`ifdef SO_WB_ALIGN_CHECK_EN
        run_start(64'h4_0010, 0, -1, 1'b0, 1'b0);
        chk("align_err_1cyc", 128'(error), 128'(1));
        repeat (20) tick();
        end_checks("align", 1'b0, 1'b1);
`else
        run_start(64'h4_0010, NB, -1, 1'b0, 1'b0);
        wait_end("unaligned", 20000);
        end_checks("unaligned", 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
